// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main controller FSM with retired-instruction counter
// Optional ADDI support via MULTICYCLE_CONTROL_ADDI_EN.
module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'd0,
   parameter logic [5:0] OP_LW    = 6'd35,
   parameter logic [5:0] OP_SW    = 6'd43,
   parameter logic [5:0] OP_BEQ   = 6'd4,
   parameter logic [5:0] OP_J     = 6'd2
`ifdef MULTICYCLE_CONTROL_ADDI_EN
   ,
   parameter logic [5:0] OP_ADDI  = 6'd8
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        illegal_op,
   output logic [3:0]  state,
   output logic [31:0] instr_retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDI_EX = 4'd10,
      S_ADDI_WB = 4'd11
   } state_t;

   state_t      state_q;
   logic [31:0] retired_q;
   logic        is_lw_q;
   logic        opcode_legal;

   assign state         = state_q;
   assign instr_retired = retired_q;

`ifdef MULTICYCLE_CONTROL_ADDI_EN
   assign opcode_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                         (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
`else
   assign opcode_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                         (opcode == OP_BEQ) || (opcode == OP_J);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         is_lw_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH:  if (mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               // Latch load/store class so later opcode changes cannot redirect MEMADR.
               is_lw_q <= (opcode == OP_LW);
               if (opcode == OP_RTYPE)                       state_q <= S_EXEC;
               else if (opcode == OP_LW || opcode == OP_SW)  state_q <= S_MEMADR;
               else if (opcode == OP_BEQ)                    state_q <= S_BRANCH;
               else if (opcode == OP_J)                      state_q <= S_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
               else if (opcode == OP_ADDI)                   state_q <= S_ADDI_EX;
`endif
               else                                          state_q <= S_FETCH;
            end
            S_MEMADR: state_q <= is_lw_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
            S_MEMWR: begin
               if (mem_ready) begin
                  state_q   <= S_FETCH;
                  retired_q <= retired_q + 32'd1;
               end
            end
            S_EXEC:   state_q <= S_RWB;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_EX: state_q <= S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
`else
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP: begin
`endif
               state_q   <= S_FETCH;
               retired_q <= retired_q + 32'd1;
            end
            default:  state_q <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      if (reset_n) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b  = 2'b11;
               illegal_op = !opcode_legal;
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            S_RWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            S_ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_ADDI_WB: reg_write = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] instr_retired;
   logic [16:0] ctrl_all;
   int          errors = 0;
   int          checks = 0;

   multicycle_control dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
      .instr_retired(instr_retired)
   );

   always #5 clk = ~clk;

   assign ctrl_all = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
      step();
      checks++;
      if (ctrl_all !== 17'd0) begin errors++; $display("FAIL reset_ctrl1 got=%h exp=0", ctrl_all); end
      step();
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++;
      if (instr_retired !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_retired); end
      checks++;
      if (ctrl_all !== 17'd0) begin errors++; $display("FAIL reset_ctrl2 got=%h exp=0", ctrl_all); end
      reset_n = 1'b1;
      #1;
      checks++;
      if (mem_read !== 1'b1) begin errors++; $display("FAIL release_mem_read got=%b exp=1", mem_read); end
   endtask

   task automatic test_rtype;
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      opcode = 6'd0; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state !== exp_s[i]) begin errors++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         if (i == 3) begin
            checks++;
            if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
               errors++; $display("FAIL rtype_rwb got=%b exp=110", {reg_write, reg_dst, mem_to_reg});
            end
         end
         if (i < 4) step();
      end
      checks++;
      if (instr_retired !== 32'd1) begin errors++; $display("FAIL rtype_count got=%0d exp=1", instr_retired); end
   endtask

   task automatic test_lw_stall;
      logic [3:0] exp_s [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
      logic       mr    [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      opcode = 6'd35;
      for (int i = 0; i < 9; i++) begin
         mem_ready = mr[i];
         #1;
         checks++;
         if (state !== exp_s[i]) begin errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         if (i < 8) begin
            checks++;
            if (ir_write !== (i == 2)) begin errors++; $display("FAIL lw_ir_write[%0d] got=%b exp=%b", i, ir_write, (i == 2)); end
         end
         if (i == 7) begin
            checks++;
            if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
               errors++; $display("FAIL lw_memwb got=%b exp=110", {reg_write, mem_to_reg, reg_dst});
            end
         end
         if (i < 8) step();
      end
      checks++;
      if (instr_retired !== 32'd2) begin errors++; $display("FAIL lw_count got=%0d exp=2", instr_retired); end
   endtask

   task automatic test_sw_beq_j;
      logic [3:0] sw_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      mem_ready = 1'b1; opcode = 6'd43;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state !== sw_s[i]) begin errors++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, sw_s[i]); end
         if (i == 2) opcode = 6'd35;
         if (i == 3) begin
            checks++;
            if ({mem_write, iord, mem_read} !== 3'b110) begin
               errors++; $display("FAIL sw_memwr got=%b exp=110", {mem_write, iord, mem_read});
            end
         end
         if (i < 4) step();
      end
      opcode = 6'd4;
      step();
      step();
      checks++;
      if (state !== 4'd8) begin errors++; $display("FAIL beq_state got=%0d exp=8", state); end
      checks++;
      if ({pc_write_cond, alu_op, pc_source} !== 5'b1_01_01) begin
         errors++; $display("FAIL beq_ctrl got=%b exp=10101", {pc_write_cond, alu_op, pc_source});
      end
      step();
      opcode = 6'd2;
      step();
      step();
      checks++;
      if (state !== 4'd9) begin errors++; $display("FAIL j_state got=%0d exp=9", state); end
      checks++;
      if ({pc_write, pc_source} !== 3'b110) begin errors++; $display("FAIL j_ctrl got=%b exp=110", {pc_write, pc_source}); end
      step();
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL j_return got=%0d exp=0", state); end
      checks++;
      if (instr_retired !== 32'd5) begin errors++; $display("FAIL sbj_count got=%0d exp=5", instr_retired); end
   endtask

   task automatic test_illegal;
      mem_ready = 1'b1; opcode = 6'h3F;
      checks++;
      if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_fetch got=%b exp=0", illegal_op); end
      step();
      checks++;
      if ({state, illegal_op} !== 5'b0001_1) begin errors++; $display("FAIL ill_decode got=%b exp=00011", {state, illegal_op}); end
      step();
      checks++;
      if ({state, illegal_op} !== 5'b0000_0) begin errors++; $display("FAIL ill_return got=%b exp=00000", {state, illegal_op}); end
      checks++;
      if (instr_retired !== 32'd5) begin errors++; $display("FAIL ill_count got=%0d exp=5", instr_retired); end
   endtask

   task automatic test_addi;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
      logic [31:0] exp_cnt = 32'd6;
`else
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
      logic [31:0] exp_cnt = 32'd5;
`endif
      mem_ready = 1'b1; opcode = 6'd8;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (state !== exp_s[i]) begin errors++; $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         if (i == 1) begin
            checks++;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            if (illegal_op !== 1'b0) begin errors++; $display("FAIL addi_illegal got=%b exp=0", illegal_op); end
`else
            if (illegal_op !== 1'b1) begin errors++; $display("FAIL addi_illegal got=%b exp=1", illegal_op); end
`endif
         end
         if (i < 4) step();
      end
      checks++;
      if (instr_retired !== exp_cnt) begin errors++; $display("FAIL addi_count got=%0d exp=%0d", instr_retired, exp_cnt); end
      opcode = 6'd0;
      step();
      step();
      step();
      step();
   endtask

   task automatic test_reset_mid;
      opcode = 6'd35; mem_ready = 1'b1;
      step();
      step();
      step();
      checks++;
      if (state !== 4'd3) begin errors++; $display("FAIL mid_reach got=%0d exp=3", state); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (ctrl_all !== 17'd0) begin errors++; $display("FAIL mid_ctrl got=%h exp=0", ctrl_all); end
      step();
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state); end
      checks++;
      if (instr_retired !== 32'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", instr_retired); end
      checks++;
      if (reg_write !== 1'b0) begin errors++; $display("FAIL mid_reg_write got=%b exp=0", reg_write); end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_stall();
      test_sw_beq_j();
      test_illegal();
      test_addi();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
